// File: rtl/led_fader.sv
// PWM LED fader: each channel ramps its brightness one level per prescaler step
// toward the registered on/off target, and blanks whenever the enable qualifier is low.
module led_fader #(
    parameter int WIDTH    = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] led,
    output logic             idle
);

    localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1'b1);

    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1'b1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RISING  = 2'd1,
        ST_ON      = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    logic [WIDTH-1:0]                pattern_r;
    logic                            enable_r;
    logic [PWM_BITS-1:0]             pwm_cnt_r;
    logic [PRESC_W-1:0]              presc_r;
    logic [WIDTH-1:0][PWM_BITS-1:0]  level_r;
    state_t                          state_r [WIDTH];
    logic [WIDTH-1:0]                led_r;
    logic                            idle_r;

    logic                            step_s;
    logic [PRESC_W-1:0]              presc_nxt_s;
    logic [WIDTH-1:0][PWM_BITS-1:0]  level_nxt_s;
    state_t                          state_nxt_s [WIDTH];
    logic [WIDTH-1:0]                led_nxt_s;
    logic                            idle_nxt_s;

    // Saturating one-level move toward the target; holds when no step is due.
    function automatic logic [PWM_BITS-1:0] next_level(
        input logic [PWM_BITS-1:0] lvl,
        input logic                tgt,
        input logic                stp
    );
        logic [PWM_BITS-1:0] res;
        res = lvl;
        if (stp && tgt && (lvl != LVL_MAX)) begin
            res = lvl + LVL_ONE;
        end else if (stp && !tgt && (lvl != LVL_ZERO)) begin
            res = lvl - LVL_ONE;
        end else begin
            res = lvl;
        end
        return res;
    endfunction

    function automatic logic is_settled(input state_t st);
        return (st == ST_OFF) || (st == ST_ON);
    endfunction

    // Prescaler, per-channel level update and PWM compare.
    always_comb begin
        step_s = enable_r && (presc_r == PRESC_LAST);

        if (!enable_r) begin
            presc_nxt_s = PRESC_ZERO;
        end else if (step_s) begin
            presc_nxt_s = PRESC_ZERO;
        end else begin
            presc_nxt_s = presc_r + PRESC_ONE;
        end

        for (int i = 0; i < WIDTH; i++) begin
            if (!enable_r) begin
                level_nxt_s[i] = LVL_ZERO;
            end else begin
                level_nxt_s[i] = next_level(level_r[i], pattern_r[i], step_s);
            end
            led_nxt_s[i] = enable_r && (level_r[i] > pwm_cnt_r);
        end

        idle_nxt_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            idle_nxt_s = idle_nxt_s & is_settled(state_r[i]);
        end
    end

    // Per-channel next state, judged on the level and target the channel will hold next cycle.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt_s[i] = state_r[i];
            if (!enable_r) begin
                state_nxt_s[i] = ST_OFF;
            end else begin
                case (state_r[i])
                    ST_OFF: begin
                        if (pattern_r[i]) begin
                            state_nxt_s[i] = (level_nxt_s[i] == LVL_MAX) ? ST_ON : ST_RISING;
                        end else begin
                            state_nxt_s[i] = ST_OFF;
                        end
                    end
                    ST_RISING: begin
                        if (!pattern_r[i]) begin
                            state_nxt_s[i] = (level_nxt_s[i] == LVL_ZERO) ? ST_OFF : ST_FALLING;
                        end else if (level_nxt_s[i] == LVL_MAX) begin
                            state_nxt_s[i] = ST_ON;
                        end else begin
                            state_nxt_s[i] = ST_RISING;
                        end
                    end
                    ST_ON: begin
                        if (!pattern_r[i]) begin
                            state_nxt_s[i] = (level_nxt_s[i] == LVL_ZERO) ? ST_OFF : ST_FALLING;
                        end else begin
                            state_nxt_s[i] = ST_ON;
                        end
                    end
                    ST_FALLING: begin
                        if (pattern_r[i]) begin
                            state_nxt_s[i] = (level_nxt_s[i] == LVL_MAX) ? ST_ON : ST_RISING;
                        end else if (level_nxt_s[i] == LVL_ZERO) begin
                            state_nxt_s[i] = ST_OFF;
                        end else begin
                            state_nxt_s[i] = ST_FALLING;
                        end
                    end
                    default: begin
                        state_nxt_s[i] = ST_OFF;
                    end
                endcase
            end
        end
    end

    // Input capture, counters, levels and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r <= {WIDTH{1'b0}};
            enable_r  <= 1'b0;
            pwm_cnt_r <= LVL_ZERO;
            presc_r   <= PRESC_ZERO;
            level_r   <= {WIDTH{LVL_ZERO}};
            led_r     <= {WIDTH{1'b0}};
            idle_r    <= 1'b1;
        end else begin
            pattern_r <= pattern;
            enable_r  <= enable;
            pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
            presc_r   <= presc_nxt_s;
            level_r   <= level_nxt_s;
            led_r     <= led_nxt_s;
            idle_r    <= idle_nxt_s;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_r[i] <= ST_OFF;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    assign led  = led_r;
    assign idle = idle_r;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with WIDTH=4, PWM_BITS=4, STEP_DIV=4; levels change
// at posedges 5, 9, 13, ... after a reset released just before posedge 1.
module tb_led_fader;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] pattern;
    logic [3:0] led;
    logic       idle;

    int n_vec = 0;
    int n_err = 0;

    led_fader #(.WIDTH(4), .PWM_BITS(4), .STEP_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .pattern (pattern),
        .led     (led),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        pattern = 4'b0000;
        enable  = 1'b0;
        tick(2);
    endtask

    task automatic start_run(input logic [3:0] pat);
        rst_n   = 1'b1;
        enable  = 1'b1;
        pattern = pat;
    endtask

    logic [3:0] rot_pat [6];
    logic [3:0] rot_exp [6][4];
    int         bad_led;
    int         bad_idle;
    int         duty;
    logic [3:0] others;

    initial begin
        rot_pat[0] = 4'd1; rot_pat[1] = 4'd3; rot_pat[2] = 4'd6;
        rot_pat[3] = 4'd12; rot_pat[4] = 4'd8; rot_pat[5] = 4'd0;
        // expected {ch0,ch1,ch2,ch3} just before each pattern change
        rot_exp[0] = '{4'd9,  4'd0,  4'd0,  4'd0};
        rot_exp[1] = '{4'd15, 4'd9,  4'd0,  4'd0};
        rot_exp[2] = '{4'd6,  4'd15, 4'd9,  4'd0};
        rot_exp[3] = '{4'd0,  4'd6,  4'd15, 4'd9};
        rot_exp[4] = '{4'd0,  4'd0,  4'd6,  4'd15};
        rot_exp[5] = '{4'd0,  4'd0,  4'd0,  4'd6};

        // Reset held while inputs toggle
        rst_n = 1'b0; enable = 1'b1; pattern = 4'b1111;
        tick(1); pattern = 4'b0101; enable = 1'b0;
        tick(1); pattern = 4'b1010; enable = 1'b1;
        tick(1);
        check("rst_led", led, 4'b0000);
        check("rst_idle", idle, 1'b1);
        check("rst_level0", dut.level_r[0], 4'd0);
        start_run(4'b0000);
        bad_led = 0; bad_idle = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (led !== 4'b0000) bad_led++;
            if (idle !== 1'b1) bad_idle++;
        end
        check("rst_release_led_dark_cycles", bad_led, 0);
        check("rst_release_idle_low_cycles", bad_idle, 0);

        // Rise of channel 0
        hold_reset();
        start_run(4'b0001);
        tick(4);
        check("rise_no_step_yet", dut.level_r[0], 4'd0);
        tick(1);
        check("rise_first_step", dut.level_r[0], 4'd1);
        check("rise_idle_low", idle, 1'b0);
        tick(55);
        check("rise_level14", dut.level_r[0], 4'd14);
        check("rise_idle_still_low", idle, 1'b0);
        tick(1);
        check("rise_level15", dut.level_r[0], 4'd15);
        tick(1);
        check("rise_idle_back", idle, 1'b1);
        check("rise_state_on", dut.state_r[0], 2'd2);
        duty = 0; others = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (led[0] === 1'b1) duty++;
            others = others | {led[3:1], 1'b0};
        end
        check("rise_duty15", duty, 15);
        check("rise_others_dark", others, 4'b0000);

        // Reversal of channel 1 at level 6
        hold_reset();
        start_run(4'b0010);
        tick(25);
        check("rev_level6", dut.level_r[1], 4'd6);
        check("rev_state_rising", dut.state_r[1], 2'd1);
        pattern = 4'b0000;
        tick(2);
        check("rev_state_falling", dut.state_r[1], 2'd3);
        check("rev_hold6", dut.level_r[1], 4'd6);
        tick(2);
        check("rev_level5", dut.level_r[1], 4'd5);
        for (int j = 1; j <= 5; j++) begin
            tick(4);
            check("rev_down", dut.level_r[1], 4'(5 - j));
        end
        check("rev_state_off", dut.state_r[1], 2'd0);
        tick(1);
        check("rev_idle", idle, 1'b1);

        // Enable drop with all channels at full
        hold_reset();
        start_run(4'b1111);
        tick(70);
        check("en_all15_ch3", dut.level_r[3], 4'd15);
        enable = 1'b0;
        tick(1);
        check("en_led_before_clear", led, 4'b1111);
        enable = 1'b1;
        tick(1);
        check("en_led_dark", led, 4'b0000);
        check("en_level_clear0", dut.level_r[0], 4'd0);
        check("en_level_clear3", dut.level_r[3], 4'd0);
        check("en_idle", idle, 1'b1);
        check("en_state_off", dut.state_r[2], 2'd0);
        tick(3);
        check("en_restart_wait", dut.level_r[2], 4'd0);
        tick(1);
        check("en_restart_step", dut.level_r[2], 4'd1);
        check("en_restart_idle_low", idle, 1'b0);

        // Asynchronous reset between edges at level 9
        hold_reset();
        start_run(4'b0001);
        tick(37);
        check("arst_level9", dut.level_r[0], 4'd9);
        check("arst_led_lit", led, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led_dark", led, 4'b0000);
        check("arst_level_clear", dut.level_r[0], 4'd0);
        check("arst_idle", idle, 1'b1);
        #1 rst_n = 1'b1;

        // Rotation sequence, pattern changes every 40 cycles
        hold_reset();
        start_run(rot_pat[0]);
        for (int s = 0; s < 6; s++) begin
            tick(40);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("rot_s%0d_ch%0d", s, c), dut.level_r[c], rot_exp[s][c]);
            end
            if (s < 5) pattern = rot_pat[s + 1];
        end
        tick(40);
        check("rot_final_ch3", dut.level_r[3], 4'd0);
        check("rot_final_idle", idle, 1'b1);
        check("rot_final_led", led, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
